// File: rtl/gpu_pixel_arbiter.sv
// gpu_pixel_arbiter
//   Shares the single framebuffer pixel-write port between the line (0),
//   fill (1) and arc (2) drawing engines. Arbitration is round-robin with a
//   bounded burst per owner. The winning pixel and the current command colour
//   are captured into a valid/ready output register.
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   req_i[2:0]             per-engine pixel request
//   x0_i..x2_i, y0_i..y2_i per-engine pixel coordinate
//   r_i, g_i, b_i          current command colour (shared)
//   grant_o[2:0]           one-hot grant; granted pixel is captured this edge
//   fb_valid_o, fb_ready_i output handshake
//   fb_x_o, fb_y_o         output pixel coordinate
//   fb_r_o, fb_g_o, fb_b_o output pixel colour
//   busy_o                 arbiter owned or output pixel pending

`ifndef WIDTH_BITS
`define WIDTH_BITS 11
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [2:0]                req_i,
    input  logic [`WIDTH_BITS-1:0]    x0_i,
    input  logic [`WIDTH_BITS-1:0]    x1_i,
    input  logic [`WIDTH_BITS-1:0]    x2_i,
    input  logic [`HEIGHT_BITS-1:0]   y0_i,
    input  logic [`HEIGHT_BITS-1:0]   y1_i,
    input  logic [`HEIGHT_BITS-1:0]   y2_i,
    input  logic [`CHANNEL_BITS-1:0]  r_i,
    input  logic [`CHANNEL_BITS-1:0]  g_i,
    input  logic [`CHANNEL_BITS-1:0]  b_i,
    output logic [2:0]                grant_o,
    output logic                      fb_valid_o,
    output logic [`WIDTH_BITS-1:0]    fb_x_o,
    output logic [`HEIGHT_BITS-1:0]   fb_y_o,
    output logic [`CHANNEL_BITS-1:0]  fb_r_o,
    output logic [`CHANNEL_BITS-1:0]  fb_g_o,
    output logic [`CHANNEL_BITS-1:0]  fb_b_o,
    input  logic                      fb_ready_i,
    output logic                      busy_o
);

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                     state, state_nxt;
    logic [1:0]                 owner, owner_nxt;
    logic [1:0]                 rr_ptr, rr_nxt;
    logic [7:0]                 burst_cnt, burst_nxt;
    logic                       load;
    logic                       gnt_vld;
    logic [1:0]                 gnt_idx;
    logic [2:0]                 hit;
    logic [3:0]                 req_ext;
    logic [`WIDTH_BITS-1:0]     x_sel;
    logic [`HEIGHT_BITS-1:0]    y_sel;

    logic                       vld_p1;
    logic [`WIDTH_BITS-1:0]     x_p1;
    logic [`HEIGHT_BITS-1:0]    y_p1;
    logic [`CHANNEL_BITS-1:0]   r_p1, g_p1, b_p1;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Returns {found, index}: first requester in order start, start+1, start+2 (mod 3).
    function automatic logic [2:0] rr_search(input logic [1:0] start, input logic [3:0] req);
        logic [2:0] res;
        logic [1:0] i;
        res = 3'b000;
        i   = start;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && req[i]) res = {1'b1, i};
            i = inc3(i);
        end
        return res;
    endfunction

    assign load    = !vld_p1 || fb_ready_i;
    assign req_ext = {1'b0, req_i};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Grant is gated by n_rst so every output reads zero while reset is held.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        burst_nxt = burst_cnt;
        gnt_vld   = 1'b0;
        gnt_idx   = owner;
        hit       = 3'b000;
        if (n_rst && load) begin
            if (state == OWNED && req_ext[owner] && burst_cnt < BURST_LIM) begin
                gnt_vld   = 1'b1;
                gnt_idx   = owner;
                burst_nxt = burst_cnt + 8'd1;
            end else begin
                // From OWNED the old owner is searched last, so a re-win only
                // happens when nobody else is asking.
                hit = rr_search((state == OWNED) ? inc3(owner) : rr_ptr, req_ext);
                if (hit[2]) begin
                    gnt_vld   = 1'b1;
                    gnt_idx   = hit[1:0];
                    owner_nxt = hit[1:0];
                    burst_nxt = 8'd1;
                    rr_nxt    = inc3(hit[1:0]);
                    state_nxt = OWNED;
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    assign grant_o = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;

    always_comb begin
        case (gnt_idx)
            2'd1:    begin x_sel = x1_i; y_sel = y1_i; end
            2'd2:    begin x_sel = x2_i; y_sel = y2_i; end
            default: begin x_sel = x0_i; y_sel = y0_i; end
        endcase
    end

    // ---- stage p1: registered output pixel ----
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            r_p1   <= '0;
            g_p1   <= '0;
            b_p1   <= '0;
        end else if (gnt_vld) begin
            vld_p1 <= 1'b1;
            x_p1   <= x_sel;
            y_p1   <= y_sel;
            r_p1   <= r_i;
            g_p1   <= g_i;
            b_p1   <= b_i;
        end else if (load) begin
            vld_p1 <= 1'b0;
        end
    end

    assign fb_valid_o = vld_p1;
    assign fb_x_o     = x_p1;
    assign fb_y_o     = y_p1;
    assign fb_r_o     = r_p1;
    assign fb_g_o     = g_p1;
    assign fb_b_o     = b_p1;
    assign busy_o     = (state == OWNED) || vld_p1;

endmodule

// File: doc/gpu_pixel_arbiter.md
# gpu_pixel_arbiter

Shares the single framebuffer pixel-write port between the three drawing engines: line (requester 0), fill (requester 1) and arc (requester 2). Each engine presents one pixel coordinate at a time with a request and advances on a one-cycle grant. The arbiter registers the winning pixel, together with the current command colour, into a valid/ready output stage feeding the framebuffer writer. Arbitration is round-robin with a bounded burst per owner, so no engine can starve another while still sustaining one pixel per clock.

## Interface
- `BURST_MAX`, default 16: maximum consecutive grants to one owner before rotation is forced; legal range 1..255.
- Coordinate and colour widths come from the shared `WIDTH_BITS`, `HEIGHT_BITS` and `CHANNEL_BITS` defines.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  3  per-requester pixel request; bit 0 = line, 1 = fill, 2 = arc.
- `x0_i`, `x1_i`, `x2_i`  in  `WIDTH_BITS`  pixel x for requester 0/1/2.
- `y0_i`, `y1_i`, `y2_i`  in  `HEIGHT_BITS`  pixel y for requester 0/1/2.
- `r_i`, `g_i`, `b_i`  in  `CHANNEL_BITS` each  current command colour, shared by all requesters.
- `grant_o`  out  3  one-hot; the pixel of the granted requester is captured at this edge.
- `fb_valid_o`  out  1  output pixel valid.
- `fb_x_o`  out  `WIDTH_BITS`  output pixel x.
- `fb_y_o`  out  `HEIGHT_BITS`  output pixel y.
- `fb_r_o`, `fb_g_o`, `fb_b_o`  out  `CHANNEL_BITS` each  output pixel colour.
- `fb_ready_i`  in  1  framebuffer writer accepts the pixel when `fb_valid_o` and `fb_ready_i` are both high.
- `busy_o`  out  1  high when state is OWNED or `fb_valid_o` is high; the command controller waits for this to drop before popping.

## Operation
- `load = !fb_valid_o || fb_ready_i`.
  - Grants occur only when `load` is high.
  - At most one `grant_o` bit is high per cycle.
- Registers:
  - `state` (IDLE/OWNED).
  - `owner` (2b).
  - `rr_ptr` (2b, values 0..2).
  - `burst_cnt` (8b).
  - Output pixel register.
- Search order from start point s: s, s+1, s+2, all mod 3. The first requester in that order with `req_i` high wins.
- IDLE:
  - If `load` is high and any request is present, search from `rr_ptr`.
  - Winner: grant it, set `owner` = winner, `burst_cnt` = 1, `rr_ptr` = winner+1 mod 3, go to OWNED.
  - Otherwise stay IDLE with no grant.
- OWNED, `load` high, owner requesting and `burst_cnt < BURST_MAX`: grant owner, increment `burst_cnt`.
- OWNED, `load` high, otherwise (owner dropped its request, or burst exhausted):
  - Search from `owner+1`; the old owner is last in order.
  - Winner: grant it, `owner` = winner, `burst_cnt` = 1, `rr_ptr` = winner+1.
  - A re-win by the old owner also resets `burst_cnt` to 1.
  - No winner: go to IDLE.
- OWNED, `load` low: hold all state, no grant.
- On a grant, the output register loads the winner's x/y plus `r_i`/`g_i`/`b_i`, and `fb_valid_o` is set.
- `load` high with no grant: `fb_valid_o` clears. Data is don't-care but must hold its last value.
- While `fb_valid_o` is high and `fb_ready_i` is low, all `fb_*` outputs hold stable.
- Requester contract: hold x/y stable while `req_i` is high until granted. A request dropped before grant is simply not served.

## Timing
- Reset values: `fb_valid_o`=0, all `fb_*` data=0, `grant_o`=0, `busy_o`=0, state=IDLE, `owner`=0, `rr_ptr`=0, `burst_cnt`=0.
- `grant_o` is combinational from the registered state, `req_i` and `fb_ready_i`, with the same-cycle capture.
  - The pixel appears on `fb_*` one cycle after its grant.
  - No combinational path from `req_i` or the coordinate inputs to `fb_*`.
- Throughput is one pixel per clock with `fb_ready_i` held high, including across owner switches (no bubble).
- `fb_ready_i` low with `fb_valid_o` high: zero grants that cycle. Grants resume in the same cycle `fb_ready_i` returns high.
- Simultaneous owner drop and other requests: the switch happens in that cycle.
- Reset asserted mid-burst: any pending output pixel is discarded and all registers return to reset values immediately.

## Test plan
- Only `req_i`=001, `fb_ready_i`=1, 20 cycles, x incremented on each grant -> `grant_o`=001 every cycle; `fb_x_o` sequence 0..19, each one cycle after its grant.
- `req_i`=111 held, `BURST_MAX`=4, `fb_ready_i`=1 -> grant sequence 0,0,0,0, 1,1,1,1, 2,2,2,2, 0,...; `fb_valid_o` continuously high.
- Only requester 1 requests, `BURST_MAX`=4, 10 pixels -> grants every cycle with no gap; `burst_cnt` restarts at 1 after each fourth grant.
- Requester 0 streaming, then `fb_ready_i` low for 3 cycles -> `grant_o`=000 for those 3 cycles, `fb_*` unchanged, no pixel lost or duplicated.
- Owner 2 drops `req_i` while 0 and 1 are requesting -> requester 0 is granted in that same cycle.
- Assert `n_rst` low mid-burst with `fb_valid_o`=1 -> all outputs 0 immediately; first grant after release is the lowest requesting index from `rr_ptr`=0.
